fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/fifo_uart_tx_if.sv | 21 ++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 tb/tb_fifo_uart_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the FSM state type, the fixed oversample factor and the default divisor width.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int OVERSAMPLE     = 16;
   localparam int DVSR_W_DEFAULT = 11;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read side of an upstream first-word-fall-through byte FIFO.
// The transmitter issues one-cycle pops; the FIFO presents its head byte and empty flag.
interface fifo_uart_tx_if;

   logic       fifo_empty;
   logic [7:0] fifo_rdata;
   logic       fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_rdata,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_rdata,
      input  fifo_rd_en
   );

endinterface

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: s_tick pulses every dvsr_q+1 cycles, restarting from zero on clr.
// No latency beyond the count itself; clr always wins over the wrap.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int DVSR_W = DVSR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              clr,
   input  logic [DVSR_W-1:0] dvsr_q,
   output logic              s_tick
);

   logic [DVSR_W-1:0] cnt;

   assign s_tick = (cnt == dvsr_q);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         cnt <= '0;
      end else if (clr || s_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FWFT byte FIFO: start, DATA_BITS LSB-first, stop; frames chain with no gap.
// tx goes low the cycle after the pop; the FIFO is popped only when non-empty and enable is high.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_TICKS = 16,
   parameter int DVSR_W     = DVSR_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 arst_n,
   input  logic                 enable,
   input  logic [DVSR_W-1:0]    dvsr,
   fifo_uart_tx_if.master       fifo,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam logic [5:0] OS_LAST   = 6'(OVERSAMPLE - 1);
   localparam logic [5:0] STOP_LAST = 6'(STOP_TICKS - 1);
   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [DVSR_W-1:0]    dvsr_q;
   logic [5:0]           tick_cnt;
   logic [2:0]           bit_idx;
   logic                 run;
   logic                 s_tick;
   logic                 stop_done;
   logic                 pop;

   // run blocks a pop while reset is held and on the first edge after release
   assign stop_done      = (state == STOP) && s_tick && (tick_cnt == STOP_LAST);
   assign pop            = run && enable && !fifo.fifo_empty && ((state == IDLE) || stop_done);
   assign fifo.fifo_rd_en = pop;

   uart_baud_gen #(.DVSR_W(DVSR_W)) u_baud (
      .clk    (clk),
      .arst_n (arst_n),
      .clr    (pop),
      .dvsr_q (dvsr_q),
      .s_tick (s_tick)
   );

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         shreg    <= '0;
         dvsr_q   <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
         run      <= 1'b0;
      end else begin
         run <= 1'b1;
         if (pop) begin
            state    <= START;
            tx_busy  <= 1'b1;
            tx       <= 1'b0;
            shreg    <= fifo.fifo_rdata[DATA_BITS-1:0];
            dvsr_q   <= dvsr;
            tick_cnt <= '0;
            bit_idx  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  tx      <= 1'b1;
                  tx_busy <= 1'b0;
               end
               START: if (s_tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     state    <= DATA;
                     tx       <= shreg[0];
                  end else begin
                     tick_cnt <= tick_cnt + 6'd1;
                  end
               end
               DATA: if (s_tick) begin
                  if (tick_cnt == OS_LAST) begin
                     tick_cnt <= '0;
                     if (bit_idx == BIT_LAST) begin
                        state <= STOP;
                        tx    <= 1'b1;
                     end else begin
                        // next bit is the one about to land in shreg[0]
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 6'd1;
                  end
               end
               STOP: if (s_tick) begin
                  if (tick_cnt == STOP_LAST) begin
                     tick_cnt <= '0;
                     state    <= IDLE;
                     tx_busy  <= 1'b0;
                  end else begin
                     tick_cnt <= tick_cnt + 6'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: a queue models the upstream FWFT FIFO.
// Outputs are sampled on the falling edge; k counts cycles after the pop cycle (k=0).
module tb_fifo_uart_tx;

   logic        clk     = 1'b0;
   logic        arst_n  = 1'b1;
   logic        enable  = 1'b0;
   logic [10:0] dvsr    = '0;
   logic        tx;
   logic        tx_busy;

   fifo_uart_tx_if fif ();

   fifo_uart_tx #(
      .DATA_BITS  (8),
      .STOP_TICKS (16),
      .DVSR_W     (11)
   ) dut (
      .clk     (clk),
      .arst_n  (arst_n),
      .enable  (enable),
      .dvsr    (dvsr),
      .fifo    (fif),
      .tx      (tx),
      .tx_busy (tx_busy)
   );

   always #5 clk = ~clk;

   logic [7:0] q[$];
   int vecs   = 0;
   int errs   = 0;
   int rd_cnt = 0;
   int viol   = 0;
   bit pend   = 1'b0;

   task automatic refresh();
      fif.fifo_empty = (q.size() == 0);
      fif.fifo_rdata = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   // pop strobes are sampled mid-cycle and applied just after the edge that consumes them
   always @(negedge clk) begin
      if (arst_n && fif.fifo_rd_en) begin
         rd_cnt++;
         if (fif.fifo_empty) viol++;
      end
      pend = arst_n && fif.fifo_rd_en;
   end

   always @(posedge clk) begin
      if (pend) begin
         #1;
         if (q.size() != 0) q.delete(0);
         refresh();
      end
   end

   task automatic push(input logic [7:0] b);
      @(posedge clk);
      #2;
      q.push_back(b);
      refresh();
   endtask

   task automatic wait_pop(input int budget, output bit ok, output int n);
      ok = 1'b0;
      n  = 0;
      while (!ok && n < budget) begin
         @(negedge clk);
         n++;
         if (fif.fifo_rd_en) ok = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int n;
      ok = 1'b0;
      n  = 0;
      @(negedge clk);
      while (!ok && n < budget) begin
         @(negedge clk);
         n++;
         if (!tx_busy) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      #1 arst_n = 1'b0;
      enable = 1'b1;
      q.push_back(8'h5A);
      refresh();
      #2;
      vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL reset_tx got %b exp 1", tx); end
      vecs++; if (tx_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
      vecs++; if (fif.fifo_rd_en !== 1'b0) begin errs++; $display("FAIL reset_rd_en got %b exp 0", fif.fifo_rd_en); end
      q.delete();
      refresh();
      enable = 1'b0;
      @(posedge clk);
      #1 arst_n = 1'b1;
      repeat (3) @(negedge clk);
      vecs++;
      if ({fif.fifo_rd_en, tx, tx_busy} !== 3'b010) begin
         errs++; $display("FAIL reset_release got %b exp 010", {fif.fifo_rd_en, tx, tx_busy});
      end
   endtask

   task automatic test_basic();
      bit ok; int n; int rd0;
      logic [9:0] frame;
      frame  = {1'b1, 8'hA5, 1'b0};
      dvsr   = 11'd0;
      enable = 1'b1;
      rd0    = rd_cnt;
      push(8'hA5);
      wait_pop(20, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL basic_pop got %b exp 1", ok); end
      for (int k = 1; k <= 161; k++) begin
         @(negedge clk);
         if (k <= 160) begin
            vecs++;
            if (tx !== frame[(k-1)/16]) begin
               errs++; $display("FAIL basic_tx k=%0d got %b exp %b", k, tx, frame[(k-1)/16]);
            end
         end
         if (k == 160) begin
            vecs++; if (tx_busy !== 1'b1) begin errs++; $display("FAIL basic_busy160 got %b exp 1", tx_busy); end
         end
      end
      vecs++; if (tx_busy !== 1'b0) begin errs++; $display("FAIL basic_idle161 got %b exp 0", tx_busy); end
      vecs++; if (rd_cnt - rd0 !== 1) begin errs++; $display("FAIL basic_rd_count got %0d exp 1", rd_cnt - rd0); end
   endtask

   task automatic test_empty();
      enable = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         vecs++;
         if ({fif.fifo_rd_en, tx, tx_busy} !== 3'b010) begin
            errs++; $display("FAIL empty_idle k=%0d got %b exp 010", k, {fif.fifo_rd_en, tx, tx_busy});
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok; int n;
      enable = 1'b0;
      dvsr   = 11'd3;
      push(8'h00);
      push(8'hFF);
      @(posedge clk);
      #2 enable = 1'b1;
      wait_pop(10, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL b2b_pop1 got %b exp 1", ok); end
      wait_pop(700, ok, n);
      vecs++; if (n !== 640) begin errs++; $display("FAIL b2b_gap got %0d exp 640", n); end
      vecs++; if ({tx, tx_busy} !== 2'b11) begin errs++; $display("FAIL b2b_last_stop got %b exp 11", {tx, tx_busy}); end
      @(negedge clk);
      vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL b2b_start2 got %b exp 0", tx); end
      repeat (96) @(negedge clk);
      vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL b2b_bit0_ff got %b exp 1", tx); end
      wait_idle(700, ok);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL b2b_idle got %b exp 1", ok); end
   endtask

   task automatic test_dvsr_change();
      bit ok; int n;
      enable = 1'b0;
      dvsr   = 11'd3;
      push(8'h01);
      push(8'h01);
      @(posedge clk);
      #2 enable = 1'b1;
      wait_pop(10, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL dvsr_pop1 got %b exp 1", ok); end
      for (int k = 1; k <= 639; k++) begin
         @(negedge clk);
         if (k == 100) dvsr = 11'd7;
         if (k == 64)  begin vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL dvsr_f1_k64 got %b exp 0", tx); end end
         if (k == 65)  begin vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL dvsr_f1_k65 got %b exp 1", tx); end end
         if (k == 128) begin vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL dvsr_f1_k128 got %b exp 1", tx); end end
         if (k == 129) begin vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL dvsr_f1_k129 got %b exp 0", tx); end end
      end
      wait_pop(5, ok, n);
      vecs++; if (n !== 1 || ok !== 1'b1) begin errs++; $display("FAIL dvsr_pop2 got n=%0d ok=%b exp n=1 ok=1", n, ok); end
      for (int k = 1; k <= 1281; k++) begin
         @(negedge clk);
         if (k == 128)  begin vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL dvsr_f2_k128 got %b exp 0", tx); end end
         if (k == 129)  begin vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL dvsr_f2_k129 got %b exp 1", tx); end end
         if (k == 256)  begin vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL dvsr_f2_k256 got %b exp 1", tx); end end
         if (k == 257)  begin vecs++; if (tx !== 1'b0) begin errs++; $display("FAIL dvsr_f2_k257 got %b exp 0", tx); end end
         if (k == 1280) begin vecs++; if (tx_busy !== 1'b1) begin errs++; $display("FAIL dvsr_f2_busy got %b exp 1", tx_busy); end end
      end
      vecs++; if (tx_busy !== 1'b0) begin errs++; $display("FAIL dvsr_f2_idle got %b exp 0", tx_busy); end
   endtask

   task automatic test_reset_mid();
      bit ok; int n; int rd0;
      enable = 1'b1;
      dvsr   = 11'd0;
      push(8'h3C);
      wait_pop(10, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL rmid_pop got %b exp 1", ok); end
      repeat (70) @(negedge clk);
      #1 arst_n = 1'b0;
      #1;
      vecs++;
      if ({fif.fifo_rd_en, tx, tx_busy} !== 3'b010) begin
         errs++; $display("FAIL rmid_async got %b exp 010", {fif.fifo_rd_en, tx, tx_busy});
      end
      @(posedge clk);
      @(posedge clk);
      #1 arst_n = 1'b1;
      rd0 = rd_cnt;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         vecs++;
         if ({fif.fifo_rd_en, tx, tx_busy} !== 3'b010) begin
            errs++; $display("FAIL rmid_quiet k=%0d got %b exp 010", k, {fif.fifo_rd_en, tx, tx_busy});
         end
      end
      vecs++; if (rd_cnt !== rd0) begin errs++; $display("FAIL rmid_no_pop got %0d exp %0d", rd_cnt, rd0); end
      push(8'hC3);
      wait_pop(10, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL rmid_new_pop got %b exp 1", ok); end
      wait_idle(200, ok);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL rmid_idle got %b exp 1", ok); end
   endtask

   task automatic test_enable_drop();
      bit ok; int n; int rd0; int bad;
      enable = 1'b0;
      dvsr   = 11'd0;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      rd0 = rd_cnt;
      bad = 0;
      @(posedge clk);
      #2 enable = 1'b1;
      wait_pop(10, ok, n);
      vecs++; if (ok !== 1'b1) begin errs++; $display("FAIL en_pop got %b exp 1", ok); end
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (k == 30) enable = 1'b0;
         if (k == 20) begin vecs++; if (tx !== 1'b1) begin errs++; $display("FAIL en_bit0 got %b exp 1", tx); end end
         if (k == 160) begin vecs++; if (tx_busy !== 1'b1) begin errs++; $display("FAIL en_busy160 got %b exp 1", tx_busy); end end
         if (k >= 161 && (tx !== 1'b1 || tx_busy !== 1'b0)) bad++;
      end
      vecs++; if (bad !== 0) begin errs++; $display("FAIL en_idle_after got %0d bad cycles exp 0", bad); end
      vecs++; if (rd_cnt - rd0 !== 1) begin errs++; $display("FAIL en_rd_count got %0d exp 1", rd_cnt - rd0); end
      vecs++; if (q.size() !== 2) begin errs++; $display("FAIL en_queue_left got %0d exp 2", q.size()); end
   endtask

   initial begin
      refresh();
      test_reset();
      test_basic();
      test_empty();
      test_back_to_back();
      test_dvsr_change();
      test_reset_mid();
      test_enable_drop();
      vecs++; if (viol !== 0) begin errs++; $display("FAIL rd_en_while_empty got %0d exp 0", viol); end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
